// File: rtl/mcd_mem_pkg.sv
// Shared field layout, widths and encodings for the DRAM command scheduler.
package mcd_mem_pkg;

    localparam int unsigned ADDR_LSB        = 13;
    localparam int unsigned LEN_MSB         = 12;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned LEN_W           = LEN_MSB + 1;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned CMD_W           = ADDR_LSB + ADDR_W;
    localparam int unsigned RNW_BIT         = CMD_W;
    localparam int unsigned MEM_CMD_W       = RNW_BIT + 1;
    localparam int unsigned RD_CREDIT_WORDS = 512;
    localparam int unsigned CNT_W           = 14;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WR_DATA = 2'd2
    } schedStateT;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grantT;

    typedef struct packed {
        logic              rnw;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } memCmdT;

    function automatic logic [LEN_W-1:0] cmdLen(input logic [CMD_W-1:0] cmd);
        return cmd[LEN_MSB:0];
    endfunction

endpackage

// File: rtl/mcd_rd_credit_counter.sv
// Tracks read-return words reserved but not yet drained; flags returns with nothing outstanding.
module mcd_rd_credit_counter
    import mcd_mem_pkg::*;
(
    input  logic             clk150,
    input  logic             nReset150,
    input  logic             reserve,
    input  logic [LEN_W-1:0] reserveLen,
    input  logic             retBeat,
    input  logic [LEN_W-1:0] checkLen,
    output logic             creditOk,
    output logic [CNT_W-1:0] rd_outstanding,
    output logic             err_underflow
);
    localparam int unsigned SUM_W = CNT_W + 1;

    assign creditOk = (SUM_W'(rd_outstanding) + SUM_W'(checkLen)) <= SUM_W'(RD_CREDIT_WORDS);

    // A return that coincides with a reservation is absorbed by the new credit.
    always_ff @(posedge clk150 or negedge nReset150) begin
        if (!nReset150) begin
            rd_outstanding <= '0;
            err_underflow  <= 1'b0;
        end else begin
            if (reserve && retBeat) begin
                rd_outstanding <= rd_outstanding + CNT_W'(reserveLen) - CNT_W'(1);
            end else if (reserve) begin
                rd_outstanding <= rd_outstanding + CNT_W'(reserveLen);
            end else if (retBeat) begin
                if (rd_outstanding == '0) begin
                    err_underflow <= 1'b1;
                end else begin
                    rd_outstanding <= rd_outstanding - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/mcd_mem_cmd_scheduler.sv
// Round-robin read/write command arbiter onto one memory command port, with
// per-burst write-data pacing and read-return credit reservation.
module mcd_mem_cmd_scheduler
    import mcd_mem_pkg::*;
(
    input  logic                 clk150,
    input  logic                 nReset150,
    input  logic [CMD_W-1:0]     rdCmd_data,
    input  logic                 rdCmd_valid,
    output logic                 rdCmd_ready,
    input  logic [CMD_W-1:0]     wrCmd_data,
    input  logic                 wrCmd_valid,
    output logic                 wrCmd_ready,
    input  logic [DATA_W-1:0]    wrData_data,
    input  logic                 wrData_valid,
    output logic                 wrData_ready,
    output logic [MEM_CMD_W-1:0] mem_cmd_data,
    output logic                 mem_cmd_valid,
    input  logic                 mem_cmd_ready,
    output logic [DATA_W-1:0]    mem_wrData_data,
    output logic                 mem_wrData_valid,
    input  logic                 mem_wrData_ready,
    input  logic                 rdRet_beat,
    output logic [CNT_W-1:0]     rd_outstanding,
    output logic                 err_underflow,
    output logic                 err_oversize
);
    schedStateT       state, stateNext;
    grantT            lastGrant, lastGrantNext;
    memCmdT           cmdQ, cmdNext;
    logic             cmdValidQ, cmdValidNext;
    logic [LEN_W-1:0] beatCnt, beatCntNext;
    logic             errOversizeQ, errOversizeNext;

    logic [LEN_W-1:0] rdLen;
    logic             creditOk;
    logic             rdOversize, rdOk, wrOk;
    logic             grantRd, grantWr;
    logic             isIdle, inWrData;
    logic             rdIssue, wrIssue, wrXfer;

    // Oversize reads can never gain credit, so they are drained here instead of stalling forever.
    assign rdLen      = cmdLen(rdCmd_data);
    assign rdOversize = rdCmd_valid && (rdLen > LEN_W'(RD_CREDIT_WORDS));
    assign rdOk       = rdCmd_valid && !rdOversize && creditOk;
    assign wrOk       = wrCmd_valid;
    assign grantRd    = rdOk && (!wrOk || lastGrant == GRANT_WR);
    assign grantWr    = wrOk && (!rdOk || lastGrant == GRANT_RD);
    assign isIdle     = nReset150 && (state == IDLE);
    assign inWrData   = (state == WR_DATA);
    assign rdIssue    = isIdle && grantRd;
    assign wrIssue    = isIdle && grantWr;
    assign wrXfer     = inWrData && wrData_valid && mem_wrData_ready;

    assign rdCmd_ready      = isIdle && (grantRd || rdOversize);
    assign wrCmd_ready      = wrIssue;
    assign wrData_ready     = inWrData && mem_wrData_ready;
    assign mem_wrData_valid = inWrData && wrData_valid;
    assign mem_wrData_data  = inWrData ? wrData_data : '0;
    assign mem_cmd_valid    = cmdValidQ;
    assign mem_cmd_data     = cmdQ;
    assign err_oversize     = errOversizeQ;

    mcd_rd_credit_counter uCredit (
        .clk150         (clk150),
        .nReset150      (nReset150),
        .reserve        (rdIssue && (rdLen != '0)),
        .reserveLen     (rdLen),
        .retBeat        (rdRet_beat),
        .checkLen       (rdLen),
        .creditOk       (creditOk),
        .rd_outstanding (rd_outstanding),
        .err_underflow  (err_underflow)
    );

    always_ff @(posedge clk150 or negedge nReset150) begin
        if (!nReset150) begin
            state        <= IDLE;
            lastGrant    <= GRANT_WR;
            cmdQ         <= '0;
            cmdValidQ    <= 1'b0;
            beatCnt      <= '0;
            errOversizeQ <= 1'b0;
        end else begin
            state        <= stateNext;
            lastGrant    <= lastGrantNext;
            cmdQ         <= cmdNext;
            cmdValidQ    <= cmdValidNext;
            beatCnt      <= beatCntNext;
            errOversizeQ <= errOversizeNext;
        end
    end

    always_comb begin
        stateNext       = state;
        lastGrantNext   = lastGrant;
        cmdNext         = cmdQ;
        cmdValidNext    = cmdValidQ;
        beatCntNext     = beatCnt;
        errOversizeNext = errOversizeQ;
        unique case (state)
            IDLE: begin
                if (isIdle && rdOversize) begin
                    errOversizeNext = 1'b1;
                end
                if (rdIssue) begin
                    cmdNext       = memCmdT'({1'b1, rdCmd_data});
                    cmdValidNext  = 1'b1;
                    lastGrantNext = GRANT_RD;
                    stateNext     = ISSUE;
                end else if (wrIssue) begin
                    cmdNext       = memCmdT'({1'b0, wrCmd_data});
                    cmdValidNext  = 1'b1;
                    lastGrantNext = GRANT_WR;
                    stateNext     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_cmd_ready) begin
                    cmdValidNext = 1'b0;
                    if (!cmdQ.rnw && (cmdQ.len != '0)) begin
                        beatCntNext = cmdQ.len;
                        stateNext   = WR_DATA;
                    end else begin
                        stateNext   = IDLE;
                    end
                end
            end
            WR_DATA: begin
                if (wrXfer) begin
                    beatCntNext = beatCnt - LEN_W'(1);
                    if (beatCnt == LEN_W'(1)) begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule
